// File: rtl/pb_event_array.sv
// pb_event_array: multi-channel push-button front end.
// Per channel: input synchroniser, debounced level, and press/release/long-press pulses.
module pb_event_array #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 16,
    parameter int unsigned LONG_CYCLES = 50000,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] pb,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] pressed,
    output logic [N_CH-1:0] released,
    output logic [N_CH-1:0] long_press
);

    localparam int unsigned DbW   = $clog2(DB_CYCLES + 1);
    localparam int unsigned HoldW = $clog2(LONG_CYCLES + 1);

    localparam logic [DbW-1:0]   DbLast   = DbW'(DB_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldMax  = HoldW'(LONG_CYCLES);

    // Normalised so that 1 always means "pressed" from here on.
    logic [N_CH-1:0] p;
    assign p = pb ^ {N_CH{ACTIVE_LOW}};

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        logic [DbW-1:0]         db_cnt_q, db_cnt_d;
        logic [HoldW-1:0]       hold_cnt_q, hold_cnt_d;
        logic                   level_q, level_d;
        logic                   pressed_q, pressed_d;
        logic                   released_q, released_d;
        logic                   long_q, long_d;

        assign s = sync_q[SYNC_STAGES-1];

        always_comb begin
            db_cnt_d   = db_cnt_q;
            level_d    = level_q;
            pressed_d  = 1'b0;
            released_d = 1'b0;
            if (s == level_q) begin
                db_cnt_d = '0;
            end else if (db_cnt_q == DbLast) begin
                db_cnt_d   = '0;
                level_d    = s;
                pressed_d  = s;
                released_d = ~s;
            end else begin
                db_cnt_d = db_cnt_q + DbW'(1);
            end
        end

        // Saturation at HoldMax is what limits long_press to one pulse per hold.
        always_comb begin
            hold_cnt_d = hold_cnt_q;
            long_d     = 1'b0;
            if (!level_q) begin
                hold_cnt_d = '0;
            end else if (hold_cnt_q != HoldMax) begin
                hold_cnt_d = hold_cnt_q + HoldW'(1);
                long_d     = (hold_cnt_q == HoldLast);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q     <= '0;
                db_cnt_q   <= '0;
                hold_cnt_q <= '0;
                level_q    <= 1'b0;
                pressed_q  <= 1'b0;
                released_q <= 1'b0;
                long_q     <= 1'b0;
            end else begin
                sync_q     <= {sync_q[SYNC_STAGES-2:0], p[c]};
                db_cnt_q   <= db_cnt_d;
                hold_cnt_q <= hold_cnt_d;
                level_q    <= level_d;
                pressed_q  <= pressed_d;
                released_q <= released_d;
                long_q     <= long_d;
            end
        end

        assign level[c]      = level_q;
        assign pressed[c]    = pressed_q;
        assign released[c]   = released_q;
        assign long_press[c] = long_q;
    end

endmodule

// File: tb/tb_pb_event_array.sv
// tb_pb_event_array: directed and random checks of pb_event_array against a window-based model.
// Two instances share clk/rst: one active-high, one active-low.
module tb_pb_event_array;

    localparam int N    = 4;
    localparam int SYNC = 2;
    localparam int DB   = 4;
    localparam int LONG = 20;
    localparam int LAT  = SYNC + DB;
    localparam int H    = SYNC + DB;

    logic         clk;
    logic         rst;
    logic [N-1:0] pb_hi, pb_lo;
    logic [N-1:0] level_hi, pressed_hi, released_hi, long_hi;
    logic [N-1:0] level_lo, pressed_lo, released_lo, long_lo;

    int checks;
    int errors;

    // Model state: history of sampled (normalised) inputs, level, unbounded hold length.
    logic [H-1:0] hist [2][N];
    int           hold [2][N];
    int           nr;
    logic [N-1:0] m_level [2];
    logic [N-1:0] m_pr [2];
    logic [N-1:0] m_rl [2];
    logic [N-1:0] m_lp [2];

    logic [4*N-1:0] got_hi, got_lo, exp_hi, exp_lo;
    assign got_hi = {level_hi, pressed_hi, released_hi, long_hi};
    assign got_lo = {level_lo, pressed_lo, released_lo, long_lo};
    assign exp_hi = {m_level[0], m_pr[0], m_rl[0], m_lp[0]};
    assign exp_lo = {m_level[1], m_pr[1], m_rl[1], m_lp[1]};

    pb_event_array #(
        .N_CH(N), .SYNC_STAGES(SYNC), .DB_CYCLES(DB), .LONG_CYCLES(LONG), .ACTIVE_LOW(1'b0)
    ) u_hi (
        .clk(clk), .rst(rst), .pb(pb_hi), .level(level_hi), .pressed(pressed_hi),
        .released(released_hi), .long_press(long_hi)
    );

    pb_event_array #(
        .N_CH(N), .SYNC_STAGES(SYNC), .DB_CYCLES(DB), .LONG_CYCLES(LONG), .ACTIVE_LOW(1'b1)
    ) u_lo (
        .clk(clk), .rst(rst), .pb(pb_lo), .level(level_lo), .pressed(pressed_lo),
        .released(released_lo), .long_press(long_lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Level flips once the last DB synchronised samples (all after reset) disagree with it.
    function automatic void model_step();
        if (rst) begin
            nr = 0;
            for (int i = 0; i < 2; i++) begin
                m_level[i] = '0;
                m_pr[i]    = '0;
                m_rl[i]    = '0;
                m_lp[i]    = '0;
                for (int c = 0; c < N; c++) begin
                    hist[i][c] = '0;
                    hold[i][c] = 0;
                end
            end
            return;
        end
        nr++;
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < N; c++) begin
                logic p, lv, flip;
                p  = (i == 0) ? pb_hi[c] : ~pb_lo[c];
                lv = m_level[i][c];
                hold[i][c] = lv ? hold[i][c] + 1 : 0;
                m_lp[i][c] = (hold[i][c] == LONG);
                flip = (nr >= DB);
                for (int j = 0; j < DB; j++) begin
                    if (hist[i][c][SYNC-1+j] == lv) flip = 1'b0;
                end
                m_pr[i][c] = flip & ~lv;
                m_rl[i][c] = flip & lv;
                if (flip) m_level[i][c] = ~lv;
                hist[i][c] = {hist[i][c][H-2:0], p};
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            checks++;
            if (got_hi !== '0 || got_lo !== '0) begin
                errors++;
                $display("FAIL reset_outputs got %h/%h want 0/0", got_hi, got_lo);
            end
        end
        rst = 1'b0;
        for (int n = 0; n < 8; n++) begin
            tick();
            checks++;
            if (got_hi !== exp_hi || got_lo !== exp_lo) begin
                errors++;
                $display("FAIL reset_idle got %h/%h want %h/%h", got_hi, got_lo, exp_hi, exp_lo);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [N-1:0] want_lvl, want_pr;
        pb_hi[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            want_lvl = (k >= 5) ? 4'b0001 : 4'b0000;
            want_pr  = (k == 5) ? 4'b0001 : 4'b0000;
            checks++;
            if (level_hi !== want_lvl || pressed_hi !== want_pr) begin
                errors++;
                $display("FAIL clean_press edge %0d got level %b pressed %b want %b %b",
                         k, level_hi, pressed_hi, want_lvl, want_pr);
            end
            checks++;
            if (got_hi !== exp_hi) begin
                errors++;
                $display("FAIL clean_model got %h want %h", got_hi, exp_hi);
            end
        end
        pb_hi[0] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++;
            if (got_hi !== exp_hi) begin
                errors++;
                $display("FAIL clean_release_model got %h want %h", got_hi, exp_hi);
            end
        end
    endtask

    task automatic test_glitch();
        int npr, nrl;
        for (int k = 0; k < 16; k++) begin
            pb_hi[1] = (k < 3);
            tick();
            checks++;
            if ({level_hi[1], pressed_hi[1], released_hi[1]} !== 3'b000) begin
                errors++;
                $display("FAIL glitch_reject got %b want 000",
                         {level_hi[1], pressed_hi[1], released_hi[1]});
            end
            checks++;
            if (got_hi !== exp_hi) begin
                errors++;
                $display("FAIL glitch_model got %h want %h", got_hi, exp_hi);
            end
        end
        npr = 0;
        nrl = 0;
        for (int k = 0; k < 24; k++) begin
            pb_hi[1] = (k < 4);
            tick();
            if (pressed_hi[1]) npr++;
            if (released_hi[1]) nrl++;
            checks++;
            if (got_hi !== exp_hi) begin
                errors++;
                $display("FAIL pulse4_model got %h want %h", got_hi, exp_hi);
            end
        end
        checks++;
        if (npr !== 1 || nrl !== 1) begin
            errors++;
            $display("FAIL pulse4_events got pressed %0d released %0d want 1 1", npr, nrl);
        end
    endtask

    task automatic test_long_press();
        int l_edge, nlp, lp_at, rel_at, npr, nrl;
        pb_hi[2] = 1'b1;
        l_edge = -1;
        for (int k = 0; k < 20 && l_edge < 0; k++) begin
            tick();
            if (level_hi[2]) l_edge = k;
        end
        checks++;
        if (l_edge < 0) begin
            errors++;
            $display("FAIL long_rise_timeout got no level want level[2]=1");
        end
        nlp = 0;
        lp_at = -1;
        for (int j = 1; j <= 30; j++) begin
            tick();
            if (long_hi[2]) begin
                nlp++;
                lp_at = j;
            end
            checks++;
            if (got_hi !== exp_hi) begin
                errors++;
                $display("FAIL long_model got %h want %h", got_hi, exp_hi);
            end
        end
        checks++;
        if (nlp !== 1 || lp_at !== LONG) begin
            errors++;
            $display("FAIL long_pulse got %0d pulses at %0d want 1 at %0d", nlp, lp_at, LONG);
        end
        pb_hi[2] = 1'b0;
        rel_at = -1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (released_hi[2] && rel_at < 0) rel_at = n;
        end
        checks++;
        if (rel_at !== LAT) begin
            errors++;
            $display("FAIL long_release got %0d want %0d", rel_at, LAT);
        end
        npr = 0;
        nrl = 0;
        nlp = 0;
        for (int n = 0; n < 30; n++) begin
            pb_hi[2] = (n < 10);
            tick();
            if (pressed_hi[2]) npr++;
            if (released_hi[2]) nrl++;
            if (long_hi[2]) nlp++;
            checks++;
            if (got_hi !== exp_hi) begin
                errors++;
                $display("FAIL short_hold_model got %h want %h", got_hi, exp_hi);
            end
        end
        checks++;
        if (npr !== 1 || nrl !== 1 || nlp !== 0) begin
            errors++;
            $display("FAIL short_hold got p%0d r%0d l%0d want p1 r1 l0", npr, nrl, nlp);
        end
    endtask

    task automatic test_active_low();
        int pr_at;
        for (int n = 0; n < 4; n++) begin
            tick();
            checks++;
            if (got_lo !== '0) begin
                errors++;
                $display("FAIL active_low_idle got %h want 0", got_lo);
            end
        end
        pb_lo[3] = 1'b0;
        pr_at = -1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (pressed_lo[3] && pr_at < 0) pr_at = n;
            checks++;
            if (got_lo !== exp_lo) begin
                errors++;
                $display("FAIL active_low_model got %h want %h", got_lo, exp_lo);
            end
        end
        checks++;
        if (pr_at !== LAT) begin
            errors++;
            $display("FAIL active_low_press got %0d want %0d", pr_at, LAT);
        end
        pb_lo[3] = 1'b1;
        for (int n = 0; n < 12; n++) tick();
    endtask

    task automatic test_reset_mid_hold();
        int l_edge, pr_at, bad;
        pb_hi[0] = 1'b1;
        l_edge = -1;
        for (int k = 0; k < 20 && l_edge < 0; k++) begin
            tick();
            if (level_hi[0]) l_edge = k;
        end
        checks++;
        if (l_edge < 0) begin
            errors++;
            $display("FAIL midhold_rise_timeout got no level want level[0]=1");
        end
        for (int n = 0; n < 10; n++) tick();
        rst = 1'b1;
        for (int n = 0; n < 2; n++) begin
            tick();
            checks++;
            if (got_hi !== '0 || got_lo !== '0) begin
                errors++;
                $display("FAIL midhold_reset got %h/%h want 0/0", got_hi, got_lo);
            end
        end
        rst = 1'b0;
        pr_at = -1;
        bad = 0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (pressed_hi[0] && pr_at < 0) pr_at = n;
            if (released_hi[0] || long_hi[0]) bad++;
            checks++;
            if (got_hi !== exp_hi) begin
                errors++;
                $display("FAIL midhold_model got %h want %h", got_hi, exp_hi);
            end
        end
        checks++;
        if (pr_at !== LAT || bad !== 0) begin
            errors++;
            $display("FAIL midhold_repress got at %0d extra %0d want at %0d extra 0",
                     pr_at, bad, LAT);
        end
        pb_hi[0] = 1'b0;
        for (int n = 0; n < 15; n++) tick();
    endtask

    task automatic test_simultaneous();
        int pr0, pr3;
        pb_hi = 4'b1001;
        pr0 = -1;
        pr3 = -1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (pressed_hi[0] && pr0 < 0) pr0 = n;
            if (pressed_hi[3] && pr3 < 0) pr3 = n;
        end
        checks++;
        if (pr0 !== LAT || pr3 !== LAT) begin
            errors++;
            $display("FAIL simul_press got %0d/%0d want %0d/%0d", pr0, pr3, LAT, LAT);
        end
        pb_hi = 4'b0000;
        for (int n = 0; n < 12; n++) tick();
        pr0 = -1;
        pr3 = -1;
        for (int n = 1; n <= 14; n++) begin
            pb_hi[0] = 1'b1;
            pb_hi[3] = !(n == 2 || n == 3);
            tick();
            if (pressed_hi[0] && pr0 < 0) pr0 = n;
            if (pressed_hi[3] && pr3 < 0) pr3 = n;
            checks++;
            if (got_hi !== exp_hi) begin
                errors++;
                $display("FAIL bounce_model got %h want %h", got_hi, exp_hi);
            end
        end
        checks++;
        if (pr0 !== LAT || pr3 !== LAT + 3) begin
            errors++;
            $display("FAIL bounce_press got %0d/%0d want %0d/%0d", pr0, pr3, LAT, LAT + 3);
        end
        pb_hi = 4'b0000;
        for (int n = 0; n < 12; n++) tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 2000; n++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 24) == 0) pb_hi[c] = ~pb_hi[c];
                if ($urandom_range(0, 24) == 0) pb_lo[c] = ~pb_lo[c];
            end
            rst = ($urandom_range(0, 399) == 0);
            tick();
            checks++;
            if (got_hi !== exp_hi || got_lo !== exp_lo) begin
                errors++;
                $display("FAIL random_model got %h/%h want %h/%h", got_hi, got_lo, exp_hi, exp_lo);
            end
            checks++;
            if ((pressed_hi & released_hi) !== '0 || (pressed_lo & released_lo) !== '0) begin
                errors++;
                $display("FAIL random_exclusive got %b/%b want 0/0",
                         pressed_hi & released_hi, pressed_lo & released_lo);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        pb_hi  = '0;
        pb_lo  = '1;
        model_step();
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_glitch();
        test_long_press();
        test_active_low();
        test_reset_mid_hold();
        test_simultaneous();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pb_event_array.md
Name: pb_event_array

Overview:
Parametrised, multi-channel push-button front end, and the successor to the single-channel synchroniser/release detector.
- Per channel: synchronises the raw button, debounces it with a stability counter, and exposes a clean level.
- Per channel: emits one-cycle press, release and long-press pulses.
- Sits between board button pins and control logic (mode select, arming, calibration trigger).
- All channels are independent and share one clock.

Parameters:
N_CH, 4, number of independent button channels (>=1).
SYNC_STAGES, 2, synchroniser flops per channel (>=2).
DB_CYCLES, 16, consecutive cycles the synchronised input must differ from level before level changes (>=1).
LONG_CYCLES, 50000, cycles level must stay high after a press before long_press fires (>=1).
ACTIVE_LOW, 1, 1 = raw pb is low when pressed (inverted at input); 0 = high when pressed.

Ports:
clk  input  1  system clock; single clock domain for everything.
rst  input  1  reset, synchronous, active-high.
pb  input  N_CH  raw asynchronous button inputs.
level  output  N_CH  debounced pressed state (1 = pressed), registered.
pressed  output  N_CH  one-cycle pulse on debounced 0->1.
released  output  N_CH  one-cycle pulse on debounced 1->0.
long_press  output  N_CH  one-cycle pulse once per hold, after LONG_CYCLES of continuous press.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst; clk and rst are sampled only at the posedge of clk.

Polarity and synchroniser:
- Input is normalised first: p = pb XOR ACTIVE_LOW (per bit).
- p then passes through a SYNC_STAGES flop chain; the chain output is s.
- No logic between synchroniser flops.

Debounce, per channel:
- Counter db_cnt, width $clog2(DB_CYCLES+1).
- If s == level: db_cnt <= 0.
- Else if db_cnt == DB_CYCLES-1: level <= s, db_cnt <= 0.
- Else: db_cnt <= db_cnt+1.
- A glitch shorter than DB_CYCLES cycles (at s) never changes level; any return of s to level clears the count.
- Latency: a clean p edge arriving before edge k makes level change after edge k+SYNC_STAGES+DB_CYCLES-1.

Events, all registered and asserted on the same edge that updates level:
- pressed = 1 for exactly one cycle when level goes 0->1.
- released = 1 for exactly one cycle when level goes 1->0.
- pressed and released are never both high on the same channel in the same cycle.

Long press, per channel:
- Counter hold_cnt, width $clog2(LONG_CYCLES+1).
- While level == 0: hold_cnt <= 0.
- While level == 1: hold_cnt increments, saturating at LONG_CYCLES.
- long_press pulses for one cycle on the edge where hold_cnt goes LONG_CYCLES-1 -> LONG_CYCLES.
- With level rising after edge L, long_press is high after edge L+LONG_CYCLES.
- It fires at most once per press. Continued holding after saturation produces no further pulses.
- A release before saturation produces released only, no long_press.
- released still pulses after a long press.

Reset:
- While rst = 1 at a posedge, the next state is: synchroniser flops = 0, db_cnt = 0, hold_cnt = 0, level = 0, pressed = released = long_press = 0.
- Reset mid-operation aborts all counts with no event pulses.
- A button held through reset is treated as a new press. pressed fires SYNC_STAGES+DB_CYCLES cycles after rst deasserts, and released is never emitted for the pre-reset press.

Channel independence: simultaneous activity on several channels yields independent, possibly coincident pulses.

Test Plan:
1. Clean press: N_CH=4, SYNC=2, DB=4, LONG=20, ACTIVE_LOW=0; pb[0] 0->1 before edge 0 and held -> level[0] and pressed[0] high after edge 5; pressed[0] low after edge 6; channels 1-3 stay 0.
2. Glitch rejection: same config, pb[1] high for 3 cycles then low -> level[1], pressed[1] and released[1] stay 0 throughout. A 4-cycle-stable pulse instead -> pressed[1] fires.
3. Release and long press: pb[2] held 30 cycles after level[2] rises at edge L -> long_press[2] one cycle after edge L+20 and never again. On release, released[2] pulses SYNC+DB cycles after pb falls. A 10-cycle hold gives released only, no long_press.
4. Active-low: ACTIVE_LOW=1, pb held 1 -> all outputs 0. Drive pb[3] low -> pressed[3] after SYNC+DB cycles.
5. Reset mid-hold: pb[0] held, assert rst for 2 cycles while hold_cnt=10 -> outputs 0 during reset, no released or long_press. pressed[0] re-fires 6 cycles after rst deasserts.
6. Simultaneous: pb[0] and pb[3] rise on the same edge -> pressed[0] and pressed[3] coincident. Bounce pb[3] for 2 cycles -> only channel 3 timing shifts.
